// File: rtl/spi_ram_pkg.sv
// ---------------------------------------------------------------------------
// spi_ram_pkg
// Shared definitions for the SPI SRAM sequencer: command opcodes, the
// controller state encoding, shift/bit-counter widths and a byte-order helper.
// ---------------------------------------------------------------------------
package spi_ram_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  // Command word is {cmd[7:0], addr[23:0]}; data words are at most 4 bytes.
  localparam int SR_W  = 32;
  // Bit counter counts down from 31 at most.
  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_HOLD,
    ST_END
  } state_t;

  // The bus puts byte 0 in bits 7:0, but the wire sends byte 0 first and the
  // shifter sends from bit 31, so byte order is reversed on load and unload.
  function automatic logic [31:0] byte_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/spi_ram_shift.sv
// ---------------------------------------------------------------------------
// spi_ram_shift
// 32-bit MSB-first shift register with a down-counting bit counter.
//
// Ports:
//   i_clk        system clock
//   i_rstn       synchronous reset, active-low
//   i_load       load i_load_data / i_load_cnt (has priority)
//   i_load_data  parallel load value
//   i_load_cnt   bit counter load value (bits remaining minus 1)
//   i_shift      shift left by one, inserting i_shift_bit at bit 0
//   i_shift_bit  bit inserted on shift (0 for shift-out, miso for shift-in)
//   i_count      decrement the bit counter
//   o_msb        current bit 31 (the bit on the wire)
//   o_data       full register contents
//   o_cnt_zero   bit counter is zero (current bit is the last one)
// ---------------------------------------------------------------------------
module spi_ram_shift
  import spi_ram_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_load,
  input  logic [SR_W-1:0]   i_load_data,
  input  logic [CNT_W-1:0]  i_load_cnt,
  input  logic              i_shift,
  input  logic              i_shift_bit,
  input  logic              i_count,
  output logic              o_msb,
  output logic [SR_W-1:0]   o_data,
  output logic              o_cnt_zero
);

  logic [SR_W-1:0]  r_data;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
      r_cnt  <= i_load_cnt;
    end else begin
      if (i_shift) r_data <= {r_data[SR_W-2:0], i_shift_bit};
      if (i_count) r_cnt  <= r_cnt - 1'b1;
    end
  end

  assign o_msb      = r_data[SR_W-1];
  assign o_data     = r_data;
  assign o_cnt_zero = (r_cnt == '0);

endmodule

// File: rtl/spi_ram_ctrl.sv
// ---------------------------------------------------------------------------
// spi_ram_ctrl
// Turns one 1..4 byte bus request into a single SPI SRAM transaction
// (select, 03h/02h command + 24-bit address, data, deselect), SPI mode 0,
// SPI clock = clk/2. Each SPI bit spends one clk cycle with spi_clk low
// (phase 0, mosi valid) and one with spi_clk high (phase 1).
//
// Optional build macro SPI_RAM_CTRL_SEQ_EN: after the data phase the chip
// stays selected (HOLD); a following request of the same direction at the
// next consecutive address continues the burst without a new command.
//
// Ports:
//   i_clk, i_rstn       clock, synchronous active-low reset
//   i_req_valid/o_req_ready  request handshake
//   i_req_write         1 = write (02h), 0 = read (03h)
//   i_req_addr          byte address
//   i_req_size          byte count minus 1
//   i_req_wdata         write data, byte k at bits 8k+7:8k
//   o_rsp_done          one-cycle completion pulse
//   o_rsp_rdata         read data (valid with o_rsp_done, held until next read)
//   o_spi_select        chip select, active-low
//   o_spi_clk, o_spi_mosi, i_spi_miso  SPI bus
// ---------------------------------------------------------------------------
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [1:0]        i_req_size,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_done,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_spi_select,
  output logic              o_spi_clk,
  output logic              o_spi_mosi,
  input  logic              i_spi_miso
);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_phase;
  logic        r_write;
  logic [1:0]  r_size;
  logic [31:0] r_wdata;
  logic        r_rsp_done;
  logic [31:0] r_rsp_rdata;

  logic             w_accept;
  logic             w_last;
  logic             w_load;
  logic [SR_W-1:0]  w_load_data;
  logic [CNT_W-1:0] w_load_cnt;
  logic             w_shift;
  logic             w_shift_bit;
  logic             w_count;
  logic             w_sr_msb;
  logic [SR_W-1:0]  w_sr_data;
  logic             w_cnt_zero;
  logic [31:0]      w_rdata;

`ifdef SPI_RAM_CTRL_SEQ_EN
  logic [ADDR_W-1:0] r_next_addr;
  logic              w_seq_hit;

  assign w_seq_hit = (r_state == ST_HOLD) && (i_req_write == r_write) &&
                     (i_req_addr == r_next_addr);
`endif

  assign w_accept = i_req_valid && o_req_ready;

  spi_ram_shift u_shift (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_load      (w_load),
    .i_load_data (w_load_data),
    .i_load_cnt  (w_load_cnt),
    .i_shift     (w_shift),
    .i_shift_bit (w_shift_bit),
    .i_count     (w_count),
    .o_msb       (w_sr_msb),
    .o_data      (w_sr_data),
    .o_cnt_zero  (w_cnt_zero)
  );

  // Received bytes sit in the low 8n bits with the first byte highest;
  // byte k of the response is therefore at shifter byte (size - k).
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rd_byte
      assign w_rdata[8*gi +: 8] = (2'(gi) <= r_size) ?
                                  w_sr_data[{r_size - 2'(gi), 3'b000} +: 8] : 8'h00;
    end
  endgenerate

  // State register and captured request / response registers.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state     <= ST_IDLE;
      r_phase     <= 1'b0;
      r_write     <= 1'b0;
      r_size      <= 2'd0;
      r_wdata     <= 32'd0;
      r_rsp_done  <= 1'b0;
      r_rsp_rdata <= 32'd0;
`ifdef SPI_RAM_CTRL_SEQ_EN
      r_next_addr <= '0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_rsp_done <= w_last;
      // Phase alternates only while bits are on the wire; every entry into
      // CMD or DATA therefore starts at phase 0.
      if (r_state == ST_CMD || r_state == ST_DATA) r_phase <= ~r_phase;
      else                                          r_phase <= 1'b0;
      if (w_accept) begin
        r_write <= i_req_write;
        r_size  <= i_req_size;
        r_wdata <= i_req_wdata;
`ifdef SPI_RAM_CTRL_SEQ_EN
        r_next_addr <= i_req_addr +
                       {{(ADDR_W-3){1'b0}}, ({1'b0, i_req_size} + 3'd1)};
`endif
      end
      if (w_last && !r_write) r_rsp_rdata <= w_rdata;
    end
  end

  // Next-state and shifter control.
  always_comb begin
    w_state_next = r_state;
    w_last       = 1'b0;
    w_load       = 1'b0;
    w_load_data  = '0;
    w_load_cnt   = '0;
    w_shift      = 1'b0;
    w_shift_bit  = 1'b0;
    w_count      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_CMD;
          w_load       = 1'b1;
          w_load_data  = {(i_req_write ? CMD_WRITE : CMD_READ), i_req_addr};
          w_load_cnt   = CNT_W'(SR_W - 1);
        end
      end
      ST_CMD: begin
        // Advance to the next bit only after its high phase.
        if (r_phase) begin
          if (w_cnt_zero) begin
            w_state_next = ST_DATA;
            w_load       = 1'b1;
            w_load_data  = r_write ? byte_swap(r_wdata) : '0;
            w_load_cnt   = {r_size, 3'b111};
          end else begin
            w_shift = 1'b1;
            w_count = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (!r_phase) begin
          // This edge raises spi_clk: miso is stable, capture it now.
          if (!r_write) begin
            w_shift     = 1'b1;
            w_shift_bit = i_spi_miso;
          end
        end else if (w_cnt_zero) begin
          w_last = 1'b1;
`ifdef SPI_RAM_CTRL_SEQ_EN
          w_state_next = ST_HOLD;
`else
          w_state_next = ST_END;
`endif
        end else begin
          w_count = 1'b1;
          if (r_write) w_shift = 1'b1;
        end
      end
`ifdef SPI_RAM_CTRL_SEQ_EN
      ST_HOLD: begin
        if (i_req_valid) begin
          if (w_seq_hit) begin
            w_state_next = ST_DATA;
            w_load       = 1'b1;
            w_load_data  = i_req_write ? byte_swap(i_req_wdata) : '0;
            w_load_cnt   = {i_req_size, 3'b111};
          end else begin
            w_state_next = ST_END;
          end
        end
      end
`endif
      ST_END:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    o_spi_select = 1'b1;
    o_spi_clk    = 1'b0;
    o_spi_mosi   = 1'b0;
    o_req_ready  = 1'b0;
    case (r_state)
      ST_IDLE: o_req_ready = 1'b1;
      ST_CMD: begin
        o_spi_select = 1'b0;
        o_spi_clk    = r_phase;
        o_spi_mosi   = w_sr_msb;
      end
      ST_DATA: begin
        o_spi_select = 1'b0;
        o_spi_clk    = r_phase;
        o_spi_mosi   = r_write & w_sr_msb;
      end
`ifdef SPI_RAM_CTRL_SEQ_EN
      ST_HOLD: begin
        o_spi_select = 1'b0;
        // A non-continuing request is refused here; it is taken in IDLE
        // after the chip has been deselected.
        o_req_ready  = !i_req_valid || w_seq_hit;
      end
`endif
      default: ;
    endcase
  end

  assign o_rsp_done  = r_rsp_done;
  assign o_rsp_rdata = r_rsp_rdata;

endmodule
